// File: rtl/data_mem_responder.sv
// Load/store data-memory responder: one request at a time, fixed latency, byte/half/word
// access with sign/zero extension on loads and lane-masked writes on stores.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] rdata,
   output logic        access_err,
   output logic        busy
);

   localparam int unsigned IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic [31:0]       mem [DEPTH_WORDS];

   logic              is_load_q, err_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic [IDXW-1:0]   idx_q;
   logic [31:0]       wdata_q;

   logic              accept;
   logic              f3_ok, misaligned, out_of_range, req_err;
   logic [3:0]        be;
   logic [31:0]       wd_lanes;
   logic [31:0]       word, load_ext;
   logic [7:0]        sel_byte;
   logic [15:0]       sel_half;

   assign req_ready = (state == IDLE) & ~rst;
   assign busy      = (state != IDLE) & ~rst;
   // Requests with neither op bit set are not accepted at all.
   assign accept    = req_valid & req_ready & (mem_read | mem_write);

   always_comb begin
      f3_ok = 1'b0;
      case (func3)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = ~mem_write;
         default:                f3_ok = 1'b0;
      endcase
      misaligned   = ((func3[1:0] == 2'b01) & addr[0]) |
                     ((func3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
      out_of_range = 32'(addr[31:2]) >= DEPTH_WORDS;
      req_err      = (mem_read & mem_write) | ~f3_ok | misaligned | out_of_range;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= 4'd1;
         else if (state == WAIT)
            cnt <= cnt + 4'd1;
         else
            cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
         WAIT: if (cnt == 4'(LATENCY - 1)) state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         is_load_q <= mem_read & ~mem_write;
         err_q     <= req_err;
         f3_q      <= func3;
         off_q     <= addr[1:0];
         idx_q     <= addr[IDXW+1:2];
         wdata_q   <= wdata;
      end
   end

   always_comb begin
      be       = 4'b1111;
      wd_lanes = wdata_q;
      case (f3_q[1:0])
         2'b00: begin
            be       = 4'b0001 << off_q;
            wd_lanes = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be       = off_q[1] ? 4'b1100 : 4'b0011;
            wd_lanes = {2{wdata_q[15:0]}};
         end
         default: begin
            be       = 4'b1111;
            wd_lanes = wdata_q;
         end
      endcase
   end

   // Store commits on the RESP edge; a reset on that edge drops it.
   always_ff @(posedge clk) begin
      if (~rst && (state == RESP) && ~is_load_q && ~err_q) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[idx_q][8*i +: 8] <= wd_lanes[8*i +: 8];
         end
      end
   end

   always_comb begin
      word     = mem[idx_q];
      sel_byte = word[{off_q, 3'b000} +: 8];
      sel_half = off_q[1] ? word[31:16] : word[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
         3'b100:  load_ext = {24'h0, sel_byte};
         3'b101:  load_ext = {16'h0, sel_half};
         default: load_ext = word;
      endcase
   end

   assign resp_valid = (state == RESP) & ~rst;
   assign access_err = resp_valid & err_q;
   assign rdata      = (resp_valid & is_load_q & ~err_q) ? load_ext : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: main checks on LATENCY=2, back-to-back throughput on LATENCY=1 and 3.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        rv1, rv2, rv3;
   logic        mem_read, mem_write;
   logic [2:0]  func3;
   logic [31:0] addr, wdata;

   logic        rdy1, rdy2, rdy3;
   logic        resp1, resp2, resp3;
   logic [31:0] rd1, rd2, rd3;
   logic        err1, err2, err3;
   logic        busy1, busy2, busy3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
      .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(rdy2),
      .mem_read(mem_read), .mem_write(mem_write), .func3(func3),
      .addr(addr), .wdata(wdata), .resp_valid(resp2), .rdata(rd2),
      .access_err(err2), .busy(busy2)
   );

   data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1),
      .mem_read(mem_read), .mem_write(mem_write), .func3(func3),
      .addr(addr), .wdata(wdata), .resp_valid(resp1), .rdata(rd1),
      .access_err(err1), .busy(busy1)
   );

   data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut_l3 (
      .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rdy3),
      .mem_read(mem_read), .mem_write(mem_write), .func3(func3),
      .addr(addr), .wdata(wdata), .resp_valid(resp3), .rdata(rd3),
      .access_err(err3), .busy(busy3)
   );

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called #1 after a rising edge with the LATENCY=2 DUT idle.
   task automatic do_req(input string tag, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_data, input logic exp_err);
      int cyc;
      check32({tag, " ready"}, 32'(rdy2), 32'd1);
      mem_read  = rd;
      mem_write = wr;
      func3     = f3;
      addr      = a;
      wdata     = wd;
      rv2       = 1'b1;
      @(posedge clk); #1;
      rv2       = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      cyc = 1;
      check32({tag, " busy/ready"}, {30'd0, busy2, rdy2}, 32'd2);
      while (!resp2 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check32({tag, " lat"}, 32'(cyc), 32'd2);
      check32({tag, " data"}, rd2, exp_data);
      check32({tag, " err"}, 32'(err2), 32'(exp_err));
      @(posedge clk); #1;
      check32({tag, " pulse"}, 32'(resp2), 32'd0);
   endtask

   initial begin
      int n_resp, n_bad, acc1, acc3, r1, r3;

      rst = 1'b1;
      rv1 = 1'b0; rv2 = 1'b0; rv3 = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0;
      func3 = 3'b000; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check32("rst ready", 32'(rdy2), 32'd0);
      check32("rst busy", 32'(busy2), 32'd0);
      check32("rst resp", 32'(resp2), 32'd0);
      check32("rst rdata", rd2, 32'd0);
      check32("rst err", 32'(err2), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check32("post rst ready", {29'd0, rdy3, rdy2, rdy1}, 32'd7);

      do_req("sw 10",  1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      do_req("lw 10",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
      do_req("lb 13",  1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
      do_req("lbu 13", 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
      do_req("lh 12",  1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
      do_req("lhu 10", 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
      // sb replaces lane 1 (0xBE) only
      do_req("sb 11",  1'b0, 1'b1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 1'b0);
      do_req("lw 10b", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
      do_req("lw 12 mis", 1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
      do_req("sh 11 mis", 1'b0, 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1);
      do_req("lw 10c", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
      do_req("lw oor", 1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
      do_req("rd+wr",  1'b1, 1'b1, 3'b010, 32'h10, 32'h11111111, 32'h0, 1'b1);
      do_req("ld f3 011", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
      do_req("st f3 100", 1'b0, 1'b1, 3'b100, 32'h10, 32'h22222222, 32'h0, 1'b1);
      do_req("lw 10d", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);

      do_req("sw 20",  1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
      mem_write = 1'b1; func3 = 3'b010; addr = 32'h20; wdata = 32'h12345678;
      rv2 = 1'b1;
      @(posedge clk); #1;
      rv2 = 1'b0; mem_write = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_resp = 0;
      for (int i = 0; i < 6; i++) begin
         if (resp2) n_resp++;
         @(posedge clk); #1;
      end
      check32("rst drop resp", 32'(n_resp), 32'd0);
      do_req("lw 20 kept", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

      do_req("sh 22",  1'b0, 1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0, 1'b0);
      do_req("lw 20b", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h8001F00D, 1'b0);
      do_req("lh 22",  1'b1, 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
      do_req("lhu 22", 1'b1, 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0);
      do_req("lb 20",  1'b1, 1'b0, 3'b000, 32'h20, 32'h0, 32'h0000000D, 1'b0);

      rv2 = 1'b1; func3 = 3'b010; addr = 32'h10;
      n_bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (resp2 || !rdy2 || busy2) n_bad++;
      end
      rv2 = 1'b0;
      check32("no-op ignored", 32'(n_bad), 32'd0);

      mem_read = 1'b1; func3 = 3'b010; addr = 32'h40;
      rv1 = 1'b1; rv3 = 1'b1;
      acc1 = 0; acc3 = 0; r1 = 0; r3 = 0; n_bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (rdy1) acc1++;
         if (rdy3) acc3++;
         if (resp1) r1++;
         if (resp3) r3++;
         if (busy1 == rdy1 || busy3 == rdy3) n_bad++;
         @(posedge clk); #1;
      end
      rv1 = 1'b0; rv3 = 1'b0; mem_read = 1'b0;
      check32("L1 accepts", 32'(acc1), 32'd6);
      check32("L1 resps", 32'(r1), 32'd6);
      check32("L3 accepts", 32'(acc3), 32'd3);
      check32("L3 resps", 32'(r3), 32'd3);
      check32("busy vs ready", 32'(n_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
